// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour codes and small helpers used by the
// sync generator and downstream pixel logic.
package vga_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int CNT_W = 10;

  // 3-bit RGB colour codes, one bit per gun
  typedef enum logic [2:0] {
    BLACK   = 3'b000,
    BLUE    = 3'b001,
    GREEN   = 3'b010,
    CYAN    = 3'b011,
    RED     = 3'b100,
    MAGENTA = 3'b101,
    YELLOW  = 3'b110,
    WHITE   = 3'b111
  } vga_colour_e;

  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } vga_pos_t;

  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_sync.sv
// VGA timing generator: clk/2 pixel enable, horizontal/vertical counters,
// registered active-low syncs and a one-clk frame-start pulse.
module vga_sync
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       f_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic     tick_q, tick_d;
  vga_pos_t pos_q, pos_d;
  logic     hsync_q, hsync_d;
  logic     vsync_q, vsync_d;

  // Counters only move on the pixel-enable clk; >= keeps a corrupted count
  // from running past the wrap point.
  always_comb begin
    tick_d = ~tick_q;
    pos_d  = pos_q;
    if (tick_q) begin
      if (pos_q.x >= H_MAX) begin
        pos_d.x = '0;
        pos_d.y = (pos_q.y >= V_MAX) ? '0 : pos_q.y + 1'b1;
      end else begin
        pos_d.x = pos_q.x + 1'b1;
      end
    end
    // Decoded from the next count so the syncs line up with pixel_x/pixel_y
    hsync_d = ~in_range(pos_d.x, HS_START, HS_END);
    vsync_d = ~in_range(pos_d.y, VS_START, VS_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q  <= 1'b0;
      pos_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      tick_q  <= tick_d;
      pos_q   <= pos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign p_tick   = tick_q;
  assign pixel_x  = pos_q.x;
  assign pixel_y  = pos_q.y;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (pos_q.x < H_VIS) && (pos_q.y < V_VIS);
  assign f_tick   = tick_q && (pos_q.x == '0) && (pos_q.y == '0);

endmodule
